pc_sequencer: RTL
=================

# pc_sequencer

Control sequencer that drives the program counter's select inputs (`pcSrc`, `interruptSignal`, `firstTimeCallAfterD2E`, `firstTimeRETAfterD2E`). It turns single-cycle decode events (branch, CALL, RET, interrupt, restart) into the multi-cycle codes the PC expects. It also performs the 32-bit return-address save and restore through the 16-bit stack memory port, and owns the stack pointer. It sits between the decode/execute boundary and the PC and stack memory, and raises `busy` to freeze the front end while a sequence runs.

## Interface
- SP_INIT, 16'h0FFF, stack pointer value after reset (first free word)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- pc  in  32  current PC value, sampled on trigger cycle
- branchTaken  in  1  taken relative branch at D/E
- isCall  in  1  CALL at D/E
- isRet  in  1  RET at D/E
- intReq  in  1  external interrupt request, level, sampled each cycle
- restartReq  in  1  soft restart request
- pcSrc  out  2  00 = pc+1, 01 = pc+aluOut, 10 = pc-1
- interruptSignal  out  2  11 = vector to 0, 01 = restart (pc = 31), 00 = none
- callCode  out  2  drives firstTimeCallAfterD2E; 11 = load aluOut
- retCode  out  2  drives firstTimeRETAfterD2E; 11 = load high half, 01 = load low half
- stackAddr  out  16  stack memory address
- stackWData  out  16  stack write data
- stackWe  out  1  stack write strobe
- stackRe  out  1  stack read strobe; data returns on memData the next cycle
- sp  out  16  current stack pointer
- busy  out  1  sequence in progress; the front end must hold decode and keep aluOut stable

## Operation
- All outputs are registered, Moore-style, and derived from the state.
- States: IDLE, BR, RST, SAVE_LO, SAVE_HI, CALL_JMP, INT_VEC, RD_HI, LD_HI, LD_LO.
- Trigger priority in IDLE, highest first: restartReq, then intReq (or intPending), then isRet, then isCall, then branchTaken. Lower-priority inputs in the same cycle are dropped; the front end re-presents them.
- **IDLE:** all strobes and codes are 0, `pcSrc` = 00, `busy` = 0.
- **BR:** `pcSrc` = 01 for one cycle, then IDLE.
- **RST:** `interruptSignal` = 01 for one cycle. `sp` reloads SP_INIT and intPending clears. Then IDLE.
- **CALL or interrupt:**
  - On the trigger cycle, latch retAddr = `pc` and a kind flag (call or int).
  - SAVE_LO: `stackWe` = 1, `stackAddr` = sp, `stackWData` = retAddr[15:0]; sp decrements.
  - SAVE_HI: same write with retAddr[31:16] at the new sp; sp decrements.
  - Then CALL_JMP (`callCode` = 11) or INT_VEC (`interruptSignal` = 11, intPending cleared).
  - Then IDLE.
- **RET:**
  - RD_HI: `stackRe` = 1, `stackAddr` = sp+1.
  - LD_HI: `retCode` = 11 (PC takes the high half from memData), `stackRe` = 1, `stackAddr` = sp+2.
  - LD_LO: `retCode` = 01; sp increments by 2.
  - Then IDLE.
- **busy:** 1 in every non-IDLE state.
- **intPending:** set by intReq in any non-IDLE state; serviced on the first IDLE cycle. An interrupt never splits a sequence.
- **sp arithmetic:** 16-bit, modulo 2^16, wraps silently. No overflow or underflow detection.
- **Reset** (asynchronous, any state, mid-sequence included):
  - state = IDLE, sp = SP_INIT, intPending = 0, retAddr = 0.
  - All outputs 0 except `sp`.
  - No partial stack write completes after reset asserts.

## Timing
- Trigger sampled at edge T; first output code visible after edge T+1.
- Branch: `pcSrc` = 01 during cycle T+1.
- Restart: `interruptSignal` = 01 during T+1.
- CALL: writes during T+1 and T+2, `callCode` = 11 during T+3; `busy` high T+1..T+3.
- Interrupt: same as CALL, with `interruptSignal` = 11 during T+3.
- RET: `stackRe` during T+1 and T+2, `retCode` = 11 during T+2, `retCode` = 01 during T+3; `busy` high T+1..T+3.
- Back-to-back: a new trigger is accepted in the first IDLE cycle after a sequence; minimum 1 IDLE cycle between sequences.

## Test plan
- Reset low mid-SAVE_HI -> `stackWe` drops immediately, sp = 0x0FFF, state IDLE, all codes 00.
- CALL with pc = 0x0001_2345, sp = 0x0FFF -> mem[0x0FFF] = 0x2345, mem[0x0FFE] = 0x0001, `callCode` = 11 at T+3, final sp = 0x0FFD.
- RET after that CALL -> reads at 0x0FFE then 0x0FFF, retCode sequence 11 then 01, PC = 0x0001_2345, sp = 0x0FFF.
- intReq pulsed during a RET sequence -> RET completes untouched, interrupt save starts the cycle after IDLE, `interruptSignal` = 11 three cycles later.
- restartReq, intReq and isCall asserted together -> only `interruptSignal` = 01 for one cycle, sp = 0x0FFF, no stack writes.
- sp = 0x0000 with CALL -> writes at 0x0000 and 0xFFFF, final sp = 0xFFFE (wrap).

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter control sequencer: expands single-cycle decode events into
// the multi-cycle PC select codes and the return-address save/restore on the stack.
module pc_sequencer #(
  parameter logic [15:0] SP_INIT = 16'h0FFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        branchTaken,
  input  logic        isCall,
  input  logic        isRet,
  input  logic        intReq,
  input  logic        restartReq,
  output logic [1:0]  pcSrc,
  output logic [1:0]  interruptSignal,
  output logic [1:0]  callCode,
  output logic [1:0]  retCode,
  output logic [15:0] stackAddr,
  output logic [15:0] stackWData,
  output logic        stackWe,
  output logic        stackRe,
  output logic [15:0] sp,
  output logic        busy,
  output logic [3:0]  dbg_state
);

  // Trigger protocol: decode events are single-cycle pulses sampled only in IDLE;
  // busy=1 tells the front end to hold decode and re-present dropped events later.
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    BR       = 4'd1,
    RST      = 4'd2,
    SAVE_LO  = 4'd3,
    SAVE_HI  = 4'd4,
    CALL_JMP = 4'd5,
    INT_VEC  = 4'd6,
    RD_HI    = 4'd7,
    LD_HI    = 4'd8,
    LD_LO    = 4'd9
  } state_t;

  state_t      state, state_n;
  logic [15:0] sp_n;
  logic [31:0] ret_addr, ret_addr_n;
  logic        kind_int, kind_int_n;
  logic        int_pending, int_pending_n;

  logic [1:0]  pc_src_n, int_sig_n, call_code_n, ret_code_n;
  logic [15:0] stack_addr_n, stack_wdata_n;
  logic        stack_we_n, stack_re_n;

  assign dbg_state = state;

  always_comb begin
    state_n       = state;
    sp_n          = sp;
    ret_addr_n    = ret_addr;
    kind_int_n    = kind_int;
    int_pending_n = int_pending;
    case (state)
      IDLE: begin
        if (restartReq) begin
          state_n       = RST;
          sp_n          = SP_INIT;
          int_pending_n = 1'b0;
        end else if (intReq || int_pending) begin
          state_n    = SAVE_LO;
          ret_addr_n = pc;
          kind_int_n = 1'b1;
        end else if (isRet) begin
          state_n = RD_HI;
        end else if (isCall) begin
          state_n    = SAVE_LO;
          ret_addr_n = pc;
          kind_int_n = 1'b0;
        end else if (branchTaken) begin
          state_n = BR;
        end
      end
      BR:       state_n = IDLE;
      RST:      state_n = IDLE;
      SAVE_LO: begin
        state_n = SAVE_HI;
        sp_n    = sp - 16'd1;
      end
      SAVE_HI: begin
        state_n = kind_int ? INT_VEC : CALL_JMP;
        sp_n    = sp - 16'd1;
      end
      CALL_JMP: state_n = IDLE;
      INT_VEC:  state_n = IDLE;
      RD_HI:    state_n = LD_HI;
      LD_HI:    state_n = LD_LO;
      LD_LO: begin
        state_n = IDLE;
        sp_n    = sp + 16'd2;
      end
      default:  state_n = IDLE;
    endcase

    // Interrupts arriving mid-sequence wait here so a sequence is never split.
    if (state == INT_VEC || state == RST)
      int_pending_n = 1'b0;
    else if (state != IDLE && intReq)
      int_pending_n = 1'b1;

    // Outputs are decoded from the state being entered so they register cleanly.
    pc_src_n      = 2'b00;
    int_sig_n     = 2'b00;
    call_code_n   = 2'b00;
    ret_code_n    = 2'b00;
    stack_addr_n  = 16'h0000;
    stack_wdata_n = 16'h0000;
    stack_we_n    = 1'b0;
    stack_re_n    = 1'b0;
    case (state_n)
      BR:       pc_src_n = 2'b01;
      RST:      int_sig_n = 2'b01;
      SAVE_LO: begin
        stack_we_n    = 1'b1;
        stack_addr_n  = sp_n;
        stack_wdata_n = ret_addr_n[15:0];
      end
      SAVE_HI: begin
        stack_we_n    = 1'b1;
        stack_addr_n  = sp_n;
        stack_wdata_n = ret_addr_n[31:16];
      end
      CALL_JMP: call_code_n = 2'b11;
      INT_VEC:  int_sig_n = 2'b11;
      RD_HI: begin
        stack_re_n   = 1'b1;
        stack_addr_n = sp_n + 16'd1;
      end
      LD_HI: begin
        ret_code_n   = 2'b11;
        stack_re_n   = 1'b1;
        stack_addr_n = sp_n + 16'd2;
      end
      LD_LO:    ret_code_n = 2'b01;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      sp              <= SP_INIT;
      ret_addr        <= 32'h0;
      kind_int        <= 1'b0;
      int_pending     <= 1'b0;
      pcSrc           <= 2'b00;
      interruptSignal <= 2'b00;
      callCode        <= 2'b00;
      retCode         <= 2'b00;
      stackAddr       <= 16'h0000;
      stackWData      <= 16'h0000;
      stackWe         <= 1'b0;
      stackRe         <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state           <= state_n;
      sp              <= sp_n;
      ret_addr        <= ret_addr_n;
      kind_int        <= kind_int_n;
      int_pending     <= int_pending_n;
      pcSrc           <= pc_src_n;
      interruptSignal <= int_sig_n;
      callCode        <= call_code_n;
      retCode         <= ret_code_n;
      stackAddr       <= stack_addr_n;
      stackWData      <= stack_wdata_n;
      stackWe         <= stack_we_n;
      stackRe         <= stack_re_n;
      busy            <= (state_n != IDLE);
    end
  end

endmodule
